// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM states, default latencies.
package md_pkg;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MFHI  = 4'd7;
    localparam logic [3:0] MFLO  = 4'd8;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    localparam int unsigned DefaultMultCycles = 5;
    localparam int unsigned DefaultDivCycles  = 10;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {hi, lo} result generator for mult/multu/div/divu.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] smul;
    logic [63:0] umul;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        neg_q;
    logic        neg_r;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign smul = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign umul = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign is_signed = (op_i == DIV);
    assign abs_a     = a_i[31] ? (32'd0 - a_i) : a_i;
    assign abs_b     = b_i[31] ? (32'd0 - b_i) : b_i;
    assign div_a     = is_signed ? abs_a : a_i;
    assign div_b     = is_signed ? abs_b : b_i;
    assign uq        = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
    assign ur        = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
    assign neg_q     = is_signed & (a_i[31] ^ b_i[31]);
    assign neg_r     = is_signed & a_i[31];

    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        case (op_i)
            MULT:  {hi_o, lo_o} = smul;
            MULTU: {hi_o, lo_o} = umul;
            DIV, DIVU: begin
                if (b_i == 32'd0) begin
                    lo_o = 32'hFFFF_FFFF;
                    hi_o = a_i;
                end else begin
                    lo_o = neg_q ? (32'd0 - uq) : uq;
                    hi_o = neg_r ? (32'd0 - ur) : ur;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler owning HI/LO and producing the D-stage stall request.
// Optional: MD_DIVZERO_EARLY_EN makes divide-by-zero a no-op that never enters RUN.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefaultMultCycles,
    parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [3:0]  E_mdOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_isMd,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] E_mfData
);

    localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

    md_state_e   state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        is_long;
    logic        is_div;
    logic        div_zero_skip;
    logic        start_long;
    logic [3:0]  load_cnt;

    md_arith u_arith (
        .op_i (E_mdOp),
        .a_i  (E_A),
        .b_i  (E_B),
        .hi_o (res_hi),
        .lo_o (res_lo)
    );

    assign is_long = is_long_op(E_mdOp);
    assign is_div  = (E_mdOp == DIV) || (E_mdOp == DIVU);

`ifdef MD_DIVZERO_EARLY_EN
    assign div_zero_skip = is_div && (E_B == 32'd0);
`else
    assign div_zero_skip = 1'b0;
`endif

    assign start_long = E_start && is_long && !div_zero_skip && (state_q == StIdle);
    assign load_cnt   = is_div ? DivCnt : MultCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_long) begin
                        state_q   <= StRun;
                        cnt_q     <= load_cnt;
                        pend_hi_q <= res_hi;
                        pend_lo_q <= res_lo;
                    end else if (E_start && (E_mdOp == MTHI)) begin
                        hi_q <= E_A;
                    end else if (E_start && (E_mdOp == MTLO)) begin
                        lo_q <= E_A;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = (state_q == StRun);
    assign md_stall = D_isMd && (busy || (E_start && is_long));
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        E_mfData = 32'd0;
        if (E_mdOp == MFHI) begin
            E_mfData = hi_q;
        end else if (E_mdOp == MFLO) begin
            E_mfData = lo_q;
        end
    end

`ifndef SYNTHESIS
    // Hazard logic must keep MD ops out of E while the unit is busy.
    assert property (@(posedge clk) disable iff (reset) !(E_start && (state_q == StRun)));
`endif

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (default 5/10-cycle latencies).
module tb_md_sched;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [3:0]  E_mdOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_isMd;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] E_mfData;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;

    md_sched dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_mdOp   (E_mdOp),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_isMd   (D_isMd),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .E_mfData (E_mfData)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op in cycle 0 and check busy/stall/HI/LO through completion at cycle n+1.
    task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int n, input logic d,
                            input logic [31:0] ehi, input logic [31:0] elo);
        E_start = 1'b1;
        E_mdOp  = op;
        E_A     = a;
        E_B     = b;
        D_isMd  = d;
        @(negedge clk);
        check_eq({tag, " busy c0"}, 32'(busy), 32'd0);
        check_eq({tag, " stall c0"}, 32'(md_stall), 32'(d));
        cyc();
        E_start = 1'b0;
        E_mdOp  = NONE;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'd1);
            check_eq($sformatf("%s stall c%0d", tag, i), 32'(md_stall), 32'(d));
            check_eq($sformatf("%s hi hold c%0d", tag, i), hi, m_hi);
            check_eq($sformatf("%s lo hold c%0d", tag, i), lo, m_lo);
            cyc();
        end
        @(negedge clk);
        check_eq({tag, " busy done"}, 32'(busy), 32'd0);
        check_eq({tag, " stall done"}, 32'(md_stall), 32'd0);
        check_eq({tag, " hi"}, hi, ehi);
        check_eq({tag, " lo"}, lo, elo);
        m_hi = ehi;
        m_lo = elo;
        cyc();
        D_isMd = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        E_start = 1'b0;
        E_mdOp  = NONE;
        E_A     = 32'd0;
        E_B     = 32'd0;
        D_isMd  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset stall", 32'(md_stall), 32'd0);
        check_eq("reset hi", hi, 32'd0);
        check_eq("reset lo", lo, 32'd0);
        check_eq("reset mfdata", E_mfData, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_long("mult", MULT, 32'd3, 32'hFFFF_FFFE, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_long("div", DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'd1, 32'hFFFF_FFFD);
        run_long("divu", DIVU, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'd7, 32'd0);
        run_long("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'd1, 32'hFFFF_FFFE);
        run_long("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);
        run_long("mult negneg", MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 5, 1'b0, 32'd0, 32'd21);

        // MTHI / MTLO then MFHI / MFLO on the following cycles.
        E_start = 1'b1;
        E_mdOp  = MTHI;
        E_A     = 32'h1234_5678;
        cyc();
        E_mdOp  = MTLO;
        E_A     = 32'h9ABC_DEF0;
        @(negedge clk);
        check_eq("mthi busy", 32'(busy), 32'd0);
        check_eq("mthi hi", hi, 32'h1234_5678);
        cyc();
        E_mdOp = MFHI;
        @(negedge clk);
        check_eq("mfhi data", E_mfData, 32'h1234_5678);
        check_eq("mtlo busy", 32'(busy), 32'd0);
        cyc();
        E_mdOp = MFLO;
        @(negedge clk);
        check_eq("mflo data", E_mfData, 32'h9ABC_DEF0);
        check_eq("mflo hi kept", hi, 32'h1234_5678);
        cyc();
        E_start = 1'b0;
        E_mdOp  = NONE;
        @(negedge clk);
        check_eq("mf none data", E_mfData, 32'd0);
        check_eq("mf no busy", 32'(busy), 32'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;
        cyc();

`ifdef MD_DIVZERO_EARLY_EN
        E_start = 1'b1;
        E_mdOp  = DIV;
        E_A     = 32'h55;
        E_B     = 32'd0;
        cyc();
        E_start = 1'b0;
        E_mdOp  = NONE;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            check_eq($sformatf("div0 busy c%0d", i), 32'(busy), 32'd0);
            cyc();
        end
        @(negedge clk);
        check_eq("div0 hi kept", hi, m_hi);
        check_eq("div0 lo kept", lo, m_lo);
        cyc();
`else
        run_long("div0", DIV, 32'h55, 32'd0, 10, 1'b0, 32'h55, 32'hFFFF_FFFF);
`endif

        // Reset in cycle 4 of a DIV: immediate clear, no later update.
        E_start = 1'b1;
        E_mdOp  = DIV;
        E_A     = 32'd100;
        E_B     = 32'd7;
        cyc();
        E_start = 1'b0;
        E_mdOp  = NONE;
        cyc();
        cyc();
        cyc();
        check_eq("rst busy before", 32'(busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst busy async", 32'(busy), 32'd0);
        check_eq("rst hi async", hi, 32'd0);
        check_eq("rst lo async", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) cyc();
        @(negedge clk);
        check_eq("rst busy after", 32'(busy), 32'd0);
        check_eq("rst hi after", hi, 32'd0);
        check_eq("rst lo after", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
